// File: rtl/div_pkg.sv
// Shared definitions for the divide sequencer: sequencer FSM encoding and the
// default operand width of the attached divider.
package div_pkg;

   localparam int unsigned DefaultWidth = 36;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StStart = 3'd2,
      StWait  = 3'd3,
      StGap   = 3'd4,
      StHold  = 3'd5
   } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock job FIFO with synchronous active-high reset.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth) + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   // Push is refused when full, so a full FIFO never sees push and pop together.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/divide_sequencer.sv
// Queues divide jobs and feeds them one at a time to an edge-started divider,
// handling zero divisors locally and bounding the wait for the divider's ready pulse.
module divide_sequencer
   import div_pkg::*;
#(
   parameter int unsigned WIDTH      = DefaultWidth,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = WIDTH + 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   input  logic [WIDTH-1:0] in_den,
   input  logic             in_sign,
   output logic             div_start,
   output logic             div_sign,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divider,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   input  logic             div_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_dz,
   output logic             out_err,
   output logic             busy
);

   localparam int unsigned EntryW = 2 * WIDTH + 1;
   localparam int unsigned CntW   = $clog2(TIMEOUT + 1);

   seq_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             div_sign_q, div_sign_d;
   logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
   logic [WIDTH-1:0] div_divider_q, div_divider_d;
   logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
   logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
   logic             out_dz_q, out_dz_d;
   logic             out_err_q, out_err_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [EntryW-1:0] fifo_wdata;
   logic [EntryW-1:0] fifo_rdata;
   logic              head_sign;
   logic [WIDTH-1:0]  head_num;
   logic [WIDTH-1:0]  head_den;

   assign in_ready   = ~fifo_full & ~reset;
   assign fifo_push  = in_valid & in_ready;
   assign fifo_wdata = {in_sign, in_num, in_den};

   assign head_sign = fifo_rdata[EntryW-1];
   assign head_num  = fifo_rdata[2*WIDTH-1:WIDTH];
   assign head_den  = fifo_rdata[WIDTH-1:0];

   sync_fifo #(
      .Width (EntryW),
      .Depth (FIFO_DEPTH)
   ) u_job_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      div_sign_d      = div_sign_q;
      div_dividend_d  = div_dividend_q;
      div_divider_d   = div_divider_q;
      out_quotient_d  = out_quotient_q;
      out_remainder_d = out_remainder_q;
      out_dz_d        = out_dz_q;
      out_err_d       = out_err_q;
      fifo_pop        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head_den == '0) begin
                  // Zero divisor is answered locally; the divider is never started.
                  state_d         = StHold;
                  out_quotient_d  = '1;
                  out_remainder_d = head_num;
                  out_dz_d        = 1'b1;
                  out_err_d       = 1'b0;
               end else begin
                  state_d        = StLoad;
                  div_sign_d     = head_sign;
                  div_dividend_d = head_num;
                  div_divider_d  = head_den;
               end
            end
         end
         StLoad: begin
            state_d = StStart;
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (div_ready) begin
               state_d         = StHold;
               out_quotient_d  = div_quotient;
               out_remainder_d = div_remainder;
               out_dz_d        = 1'b0;
               out_err_d       = 1'b0;
            end else if (cnt_d == CntW'(TIMEOUT)) begin
               state_d         = StHold;
               out_quotient_d  = '0;
               out_remainder_d = '0;
               out_dz_d        = 1'b0;
               out_err_d       = 1'b1;
            end
         end
         StHold: begin
            if (out_ready) begin
               state_d   = StGap;
               out_dz_d  = 1'b0;
               out_err_d = 1'b0;
            end
         end
         StGap: begin
            // Guarantees div_start is low for a cycle before the next rising edge.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         div_sign_q      <= 1'b0;
         div_dividend_q  <= '0;
         div_divider_q   <= '0;
         out_quotient_q  <= '0;
         out_remainder_q <= '0;
         out_dz_q        <= 1'b0;
         out_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         div_sign_q      <= div_sign_d;
         div_dividend_q  <= div_dividend_d;
         div_divider_q   <= div_divider_d;
         out_quotient_q  <= out_quotient_d;
         out_remainder_q <= out_remainder_d;
         out_dz_q        <= out_dz_d;
         out_err_q       <= out_err_d;
      end
   end

   assign div_start     = (state_q == StStart);
   assign div_sign      = div_sign_q;
   assign div_dividend  = div_dividend_q;
   assign div_divider   = div_divider_q;
   assign out_valid     = (state_q == StHold);
   assign out_quotient  = out_quotient_q;
   assign out_remainder = out_remainder_q;
   assign out_dz        = out_dz_q;
   assign out_err       = out_err_q;
   assign busy          = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_divide_sequencer.sv
// Directed bench for divide_sequencer with a behavioural edge-started divider
// whose latency and ready pulse can be adjusted between scenarios.
module tb_divide_sequencer;

   localparam int unsigned W  = 36;
   localparam int unsigned TO = W + 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_num = '0;
   logic [W-1:0] in_den = '0;
   logic         in_sign = 1'b0;
   logic         div_start;
   logic         div_sign;
   logic [W-1:0] div_dividend;
   logic [W-1:0] div_divider;
   logic [W-1:0] div_quotient;
   logic [W-1:0] div_remainder;
   logic         div_ready = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_quotient;
   logic [W-1:0] out_remainder;
   logic         out_dz;
   logic         out_err;
   logic         busy;

   divide_sequencer #(
      .WIDTH      (W),
      .FIFO_DEPTH (4),
      .TIMEOUT    (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_num        (in_num),
      .in_den        (in_den),
      .in_sign       (in_sign),
      .div_start     (div_start),
      .div_sign      (div_sign),
      .div_dividend  (div_dividend),
      .div_divider   (div_divider),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_ready     (div_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_dz        (out_dz),
      .out_err       (out_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Divider stub: rising-edge start, ready pulse lat cycles later; ignores reset.
   int unsigned  lat = 3;
   bit           tie_low = 1'b0;
   logic         start_d1 = 1'b0;
   int unsigned  mcnt = 0;
   logic [W-1:0] mq = '0;
   logic [W-1:0] mr = '0;

   always @(posedge clk) begin
      start_d1  <= div_start;
      div_ready <= 1'b0;
      if (div_start && !start_d1) begin
         mcnt <= lat;
         if (div_sign) begin
            mq <= $signed(div_dividend) / $signed(div_divider);
            mr <= $signed(div_dividend) % $signed(div_divider);
         end else begin
            mq <= div_dividend / div_divider;
            mr <= div_dividend % div_divider;
         end
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1 && !tie_low) div_ready <= 1'b1;
      end
   end

   assign div_quotient  = mq;
   assign div_remainder = mr;

   int unsigned start_pulses = 0;
   int unsigned back_to_back = 0;
   int unsigned valid_seen = 0;
   logic        prev_start = 1'b0;

   always @(negedge clk) begin
      if (div_start) begin
         if (prev_start) back_to_back++;
         else start_pulses++;
      end
      if (out_valid) valid_seen++;
      prev_start = div_start;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
      int unsigned g = 0;
      in_num   = n;
      in_den   = d;
      in_sign  = s;
      in_valid = 1'b1;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("push_accept", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic take(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dz, input logic err);
      int unsigned g = 0;
      while (!out_valid && g < 300) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_q"}, {28'd0, out_quotient}, {28'd0, q});
      chk({tag, "_r"}, {28'd0, out_remainder}, {28'd0, r});
      chk({tag, "_dz"}, {63'd0, out_dz}, {63'd0, dz});
      chk({tag, "_err"}, {63'd0, out_err}, {63'd0, err});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic wait_start();
      int unsigned g = 0;
      while (!div_start && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("wait_start", {63'd0, div_start}, 64'd1);
   endtask

   int unsigned s0;
   int unsigned d;

   initial begin
      // Reset values, sampled while reset is still asserted.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_div_start", {63'd0, div_start}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_out_q", {28'd0, out_quotient}, 64'd0);
      chk("rst_out_r", {28'd0, out_remainder}, 64'd0);
      chk("rst_dz_err", {62'd0, out_dz, out_err}, 64'd0);
      chk("rst_div_ops", {27'd0, div_sign, div_dividend}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

      // Unsigned 100 / 7; pop cycle, LOAD, then START two cycles after the pop.
      push(36'd100, 36'd7, 1'b0);
      chk("t1_pop_start", {63'd0, div_start}, 64'd0);
      @(negedge clk);
      chk("t1_load_start", {63'd0, div_start}, 64'd0);
      chk("t1_load_dividend", {28'd0, div_dividend}, 64'd100);
      chk("t1_load_divider", {28'd0, div_divider}, 64'd7);
      @(negedge clk);
      chk("t1_start", {63'd0, div_start}, 64'd1);
      take("t1", 36'd14, 36'd2, 1'b0, 1'b0);

      // Signed -100 / 7 truncates toward zero.
      push(-36'sd100, 36'd7, 1'b1);
      take("t2", -36'sd14, -36'sd2, 1'b0, 1'b0);

      // 5 / 0: result one cycle after the pop, divider untouched.
      #1 s0 = start_pulses;
      push(36'd5, 36'd0, 1'b0);
      chk("t3_pop_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("t3_valid_next", {63'd0, out_valid}, 64'd1);
      take("t3", {W{1'b1}}, 36'd5, 1'b1, 1'b0);
      chk("t3_dz_cleared", {63'd0, out_dz}, 64'd0);
      #1 chk("t3_no_start", 64'(start_pulses - s0), 64'd0);

      // Stall on a held result, fill the FIFO, then drain everything in order.
      push(36'd9, 36'd0, 1'b0);
      @(negedge clk);
      push(36'd50, 36'd5, 1'b0);
      push(36'd77, 36'd10, 1'b0);
      push(36'd1000, 36'd33, 1'b0);
      chk("t4_not_full_yet", {63'd0, in_ready}, 64'd1);
      push(-36'sd9, 36'd2, 1'b1);
      chk("t4_full", {63'd0, in_ready}, 64'd0);
      chk("t4_busy", {63'd0, busy}, 64'd1);
      #1 s0 = start_pulses;
      take("t4_j0", {W{1'b1}}, 36'd9, 1'b1, 1'b0);
      push(36'd123456, 36'd1, 1'b0);
      take("t4_j1", 36'd10, 36'd0, 1'b0, 1'b0);
      take("t4_j2", 36'd7, 36'd7, 1'b0, 1'b0);
      take("t4_j3", 36'd30, 36'd10, 1'b0, 1'b0);
      take("t4_j4", -36'sd4, -36'sd1, 1'b0, 1'b0);
      take("t4_j5", 36'd123456, 36'd0, 1'b0, 1'b0);
      #1 chk("t4_starts", 64'(start_pulses - s0), 64'd5);
      chk("t4_start_gap", 64'(back_to_back), 64'd0);

      // Divider never answers: counter reaches TIMEOUT on the TIMEOUT-th edge after
      // the START cycle, so the registered error result shows one cycle after that.
      tie_low = 1'b1;
      push(36'd20, 36'd3, 1'b0);
      wait_start();
      d = 0;
      do begin
         @(negedge clk);
         d++;
      end while (!out_valid && d < 200);
      chk("t5_latency", 64'(d), 64'(TO + 1));
      take("t5", 36'd0, 36'd0, 1'b0, 1'b1);
      chk("t5_err_cleared", {63'd0, out_err}, 64'd0);
      tie_low = 1'b0;
      push(36'd20, 36'd3, 1'b0);
      take("t5_next", 36'd6, 36'd2, 1'b0, 1'b0);

      // Reset in WAIT; the divider's late ready pulse must be ignored.
      lat = 15;
      push(36'd30, 36'd4, 1'b0);
      wait_start();
      repeat (2) @(negedge clk);
      #1 s0 = valid_seen;
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_in_ready", {63'd0, in_ready}, 64'd0);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      #1 chk("t6_no_valid", 64'(valid_seen - s0), 64'd0);
      chk("t6_idle", {63'd0, busy}, 64'd0);
      chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
      chk("t6_out_q", {28'd0, out_quotient}, 64'd0);

      // Normal operation afterwards.
      lat = 3;
      push(36'd100, 36'd7, 1'b0);
      take("t7", 36'd14, 36'd2, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
